// File: rtl/coprocessor_pkg.sv
// Shared types and constants for the coprocessor host sequencer.
// Config word layout: mu [23:16], gamma [15:8], lambda [7:0].
package coprocessor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CFG_WAIT,
    ST_WAIT_RESULT,
    ST_RELEASE,
    ST_ROW_GAP,
    ST_DONE
  } seq_state_e;

  localparam int unsigned CFG_MU_MSB     = 23;
  localparam int unsigned CFG_MU_LSB     = 16;
  localparam int unsigned CFG_GAMMA_MSB  = 15;
  localparam int unsigned CFG_GAMMA_LSB  = 8;
  localparam int unsigned CFG_LAMBDA_MSB = 7;
  localparam int unsigned CFG_LAMBDA_LSB = 0;

  localparam int unsigned CONFIG_ADDR = 0;

endpackage

// File: rtl/host_mem_bridge.sv
// Registered memory-port stage: config fetch override, else forwards the
// processor command with write taking priority over read.
module host_mem_bridge
  import coprocessor_pkg::*;
#(
  parameter int unsigned width           = 96,
  parameter int unsigned memory_size_log = 8
) (
  input  logic                       in_clk,
  input  logic                       in_reset,
  input  logic                       i_fetch,
  input  logic                       i_forward,
  input  logic                       i_proc_read_en,
  input  logic                       i_proc_write_en,
  input  logic [memory_size_log-1:0] i_proc_address,
  input  logic [width-1:0]           i_proc_data,
  output logic [memory_size_log-1:0] o_mem_address,
  output logic                       o_mem_read_en,
  output logic                       o_mem_write_en,
  output logic [width-1:0]           o_mem_data
);

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      o_mem_address  <= '0;
      o_mem_read_en  <= 1'b0;
      o_mem_write_en <= 1'b0;
      o_mem_data     <= '0;
    end else if (i_fetch) begin
      o_mem_address  <= memory_size_log'(CONFIG_ADDR);
      o_mem_read_en  <= 1'b1;
      o_mem_write_en <= 1'b0;
      o_mem_data     <= '0;
    end else if (i_forward && i_proc_write_en) begin
      o_mem_address  <= i_proc_address;
      o_mem_read_en  <= 1'b0;
      o_mem_write_en <= 1'b1;
      o_mem_data     <= i_proc_data;
    end else if (i_forward && i_proc_read_en) begin
      o_mem_address  <= i_proc_address;
      o_mem_read_en  <= 1'b1;
      o_mem_write_en <= 1'b0;
      o_mem_data     <= '0;
    end else begin
      // Idle port: enables drop, address/data hold their last value.
      o_mem_read_en  <= 1'b0;
      o_mem_write_en <= 1'b0;
    end
  end

endmodule

// File: rtl/coprocessor_host_sequencer.sv
// Host-side driver for the matrix coprocessor: fetches the job config, walks
// the lambda x gamma index grid and owns the memory port while an index is live.
module coprocessor_host_sequencer
  import coprocessor_pkg::*;
#(
  parameter int unsigned cell_width      = 32,
  parameter int unsigned index_width     = 8,
  parameter int unsigned width           = 96,
  parameter int unsigned memory_size_log = 8,
  parameter int unsigned timeout_cycles  = 4096,
  parameter int unsigned timeout_width   = 13
) (
  input  logic                       in_clk,
  input  logic                       in_reset,
  input  logic                       in_start,
  output logic                       out_busy,
  output logic                       out_done,
  output logic                       out_error,
  output logic                       out_grant,
  output logic [index_width-1:0]     out_row_index,
  output logic [index_width-1:0]     out_col_index,
  output logic                       out_index_ready,
  output logic [index_width-1:0]     out_mu,
  output logic [cell_width-1:0]      out_config,
  input  logic                       in_result_ready,
  input  logic                       in_request,
  input  logic                       in_proc_mem_read_en,
  input  logic                       in_proc_mem_write_en,
  input  logic [memory_size_log-1:0] in_proc_mem_address,
  input  logic [width-1:0]           in_proc_mem_data,
  output logic [memory_size_log-1:0] out_mem_address,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic [width-1:0]           out_mem_data,
  input  logic [width-1:0]           in_mem_data
);

  seq_state_e               r_state, w_state_next;
  logic                     r_busy, w_busy_next;
  logic                     r_done, w_done_next;
  logic                     r_error, w_error_next;
  logic                     r_grant, w_grant_next;
  logic                     r_index_ready, w_index_ready_next;
  logic [index_width-1:0]   r_row, w_row_next;
  logic [index_width-1:0]   r_col, w_col_next;
  logic [cell_width-1:0]    r_config, w_config_next;
  logic [timeout_width-1:0] r_timer, w_timer_next;

  logic                     w_start_accept;
  logic [cell_width-1:0]    w_mem_cfg;
  logic [index_width-1:0]   w_new_gamma, w_new_lambda, w_gamma, w_lambda;
  logic                     w_unused;

  assign w_start_accept = (r_state == ST_IDLE) && in_start;
  assign w_mem_cfg      = in_mem_data[cell_width-1:0];
  assign w_new_gamma    = index_width'(w_mem_cfg[CFG_GAMMA_MSB:CFG_GAMMA_LSB]);
  assign w_new_lambda   = index_width'(w_mem_cfg[CFG_LAMBDA_MSB:CFG_LAMBDA_LSB]);
  assign w_gamma        = index_width'(r_config[CFG_GAMMA_MSB:CFG_GAMMA_LSB]);
  assign w_lambda       = index_width'(r_config[CFG_LAMBDA_MSB:CFG_LAMBDA_LSB]);
  assign w_unused       = ^{in_request, in_mem_data[width-1:cell_width]};

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_grant       <= 1'b0;
      r_index_ready <= 1'b0;
      r_row         <= '0;
      r_col         <= '0;
      r_config      <= '0;
      r_timer       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
      r_error       <= w_error_next;
      r_grant       <= w_grant_next;
      r_index_ready <= w_index_ready_next;
      r_row         <= w_row_next;
      r_col         <= w_col_next;
      r_config      <= w_config_next;
      r_timer       <= w_timer_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_busy_next        = r_busy;
    w_done_next        = 1'b0;
    w_error_next       = r_error;
    w_grant_next       = r_grant;
    w_index_ready_next = r_index_ready;
    w_row_next         = r_row;
    w_col_next         = r_col;
    w_config_next      = r_config;
    w_timer_next       = r_timer;
    unique case (r_state)
      ST_IDLE: begin
        if (in_start) begin
          w_state_next = ST_FETCH;
          w_busy_next  = 1'b1;
          w_error_next = 1'b0;
          w_row_next   = '0;
          w_col_next   = '0;
        end
      end
      ST_FETCH: w_state_next = ST_CFG_WAIT;
      ST_CFG_WAIT: begin
        w_config_next = w_mem_cfg;
        if (w_new_gamma == '0 || w_new_lambda == '0) begin
          w_state_next = ST_DONE;
          w_done_next  = 1'b1;
        end else begin
          w_state_next       = ST_WAIT_RESULT;
          w_index_ready_next = 1'b1;
          w_grant_next       = 1'b1;
          w_row_next         = '0;
          w_col_next         = '0;
          w_timer_next       = '0;
        end
      end
      ST_WAIT_RESULT: begin
        // A result arriving on the final timeout cycle still counts as success.
        if (in_result_ready) begin
          w_state_next       = ST_RELEASE;
          w_index_ready_next = 1'b0;
          w_grant_next       = 1'b0;
        end else if (r_timer == timeout_width'(timeout_cycles - 1)) begin
          w_state_next       = ST_DONE;
          w_done_next        = 1'b1;
          w_error_next       = 1'b1;
          w_index_ready_next = 1'b0;
          w_grant_next       = 1'b0;
        end else begin
          w_timer_next = r_timer + timeout_width'(1);
        end
      end
      ST_RELEASE: begin
        if (r_col < w_gamma - index_width'(1)) begin
          w_state_next       = ST_WAIT_RESULT;
          w_col_next         = r_col + index_width'(1);
          w_index_ready_next = 1'b1;
          w_grant_next       = 1'b1;
          w_timer_next       = '0;
        end else if (r_row < w_lambda - index_width'(1)) begin
          w_state_next = ST_ROW_GAP;
          w_col_next   = '0;
          w_row_next   = r_row + index_width'(1);
        end else begin
          w_state_next = ST_DONE;
          w_done_next  = 1'b1;
        end
      end
      ST_ROW_GAP: begin
        w_state_next       = ST_WAIT_RESULT;
        w_index_ready_next = 1'b1;
        w_grant_next       = 1'b1;
        w_timer_next       = '0;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  host_mem_bridge #(
    .width           (width),
    .memory_size_log (memory_size_log)
  ) u_bridge (
    .in_clk          (in_clk),
    .in_reset        (in_reset),
    .i_fetch         (w_start_accept),
    .i_forward       (r_state == ST_WAIT_RESULT),
    .i_proc_read_en  (in_proc_mem_read_en),
    .i_proc_write_en (in_proc_mem_write_en),
    .i_proc_address  (in_proc_mem_address),
    .i_proc_data     (in_proc_mem_data),
    .o_mem_address   (out_mem_address),
    .o_mem_read_en   (out_mem_read_en),
    .o_mem_write_en  (out_mem_write_en),
    .o_mem_data      (out_mem_data)
  );

  assign out_busy        = r_busy;
  assign out_done        = r_done;
  assign out_error       = r_error;
  assign out_grant       = r_grant;
  assign out_index_ready = r_index_ready;
  assign out_row_index   = r_row;
  assign out_col_index   = r_col;
  assign out_config      = r_config;
  assign out_mu          = index_width'(r_config[CFG_MU_MSB:CFG_MU_LSB]);

endmodule

// File: doc/coprocessor_host_sequencer.md
# coprocessor_host_sequencer

Synthesizable host-side driver for the matrix `processor` coprocessor, and the initiator end of its index/result handshake. It reads the job configuration word from `memory`, then walks every (row, col) index of the λ×γ result grid. For each index it asserts the index handshake, waits for the result, and releases the handshake. While an index is in flight it owns the single `memory` port and forwards the processor's memory commands through one register stage. It sits between `processor` and `memory` and replaces the behavioural host in system builds.

## Interface
Parameters
- `cell_width`, 32, width of one matrix cell / config word
- `index_width`, 8, width of row/col/mu indices
- `width`, 96, memory line width (`cell_width*size`)
- `memory_size_log`, 8, memory address width
- `timeout_cycles`, 4096, maximum wait for `in_result_ready` per index
- `timeout_width`, 13, counter width, ≥ clog2(timeout_cycles+1)

Ports
- `in_clk`, in, 1, single clock; all state updates on rising edge
- `in_reset`, in, 1, asynchronous, active-high reset
- `in_start`, in, 1, start-job pulse; sampled only in IDLE
- `out_busy`, out, 1, high from leaving IDLE until DONE completes
- `out_done`, out, 1, one-cycle pulse at job end
- `out_error`, out, 1, sticky timeout flag; cleared by the next accepted `in_start`
- `out_grant`, out, 1, memory ownership granted to processor
- `out_row_index` / `out_col_index`, out, `index_width`, current index
- `out_index_ready`, out, 1, index valid
- `out_mu`, out, `index_width`, config μ
- `out_config`, out, `cell_width`, captured config word
- `in_result_ready`, in, 1, processor finished current index
- `in_request`, in, 1, processor wants memory; monitored only
- `in_proc_mem_read_en` / `in_proc_mem_write_en`, in, 1, processor memory command
- `in_proc_mem_address`, in, `memory_size_log`, processor address
- `in_proc_mem_data`, in, `width`, processor write data
- `out_mem_address`, out, `memory_size_log`, memory address
- `out_mem_read_en` / `out_mem_write_en`, out, 1, memory command
- `out_mem_data`, out, `width`, memory write data
- `in_mem_data`, in, `width`, memory read data, registered, valid one cycle after the read edge

## Operation
- States: IDLE, FETCH, CFG_WAIT, WAIT_RESULT, RELEASE, ROW_GAP, DONE.
- **IDLE.** `in_start`=1 → FETCH. Clears `out_error`, row=0, col=0. `in_start` is ignored in every other state.
- **FETCH.** Drives address 0 with read_en=1 for one cycle → CFG_WAIT.
- **CFG_WAIT.** Captures `in_mem_data[cell_width-1:0]` into the config register. Fields: μ=[23:16], γ=[15:8], λ=[7:0].
  - λ=0 or γ=0 → DONE; no index is issued.
  - Otherwise → WAIT_RESULT, with `out_index_ready`=1, `out_grant`=1, row=0, col=0.
- **WAIT_RESULT.** Each cycle the processor's command is registered onto the memory port.
  - write_en has priority: address and data are copied, read_en=0.
  - Otherwise read_en: address is copied, data=0.
  - Neither asserted: both enables are 0; address and data hold.
  - `in_result_ready`=1 → RELEASE, with `out_index_ready`=0 and `out_grant`=0. Any command presented on that edge is still forwarded.
- **RELEASE.** Advances the index.
  - col < γ−1: col+1 → WAIT_RESULT.
  - Else, row < λ−1: col=0, row+1 → ROW_GAP.
  - Else → DONE.
- **ROW_GAP.** One idle cycle → WAIT_RESULT.
- **Timeout.** The counter clears on every entry to WAIT_RESULT. If it reaches `timeout_cycles` without `in_result_ready`: `out_error`=1, `out_index_ready`=0, `out_grant`=0, → DONE.
- **DONE.** `out_done`=1 for one cycle, then → IDLE.

## Timing
- All outputs are registered.
- Reset values: every output 0, state IDLE, config 0, counters 0.
- Job start. `in_start` sampled at edge k gives:
  - read_en=1 and address 0 after edge k;
  - config captured at edge k+2;
  - `out_index_ready` and `out_grant` high after edge k+2.
- Forwarding latency: a processor command sampled at edge n appears on the memory port after edge n. Memory read data therefore returns two cycles after the processor issues the read.
- Index handshake:
  - `in_result_ready` seen at edge m → `out_index_ready` low after edge m.
  - Next index in the same row: high after edge m+1.
  - Next index in a new row: high after edge m+2.
- `out_index_ready` is low for at least one cycle between indices.
- `out_done` follows the last RELEASE by one cycle. `out_busy` falls together with the end of `out_done`.
- Row/col/μ/config are stable for the whole time `out_index_ready` is high.
- Asynchronous reset mid-job aborts immediately: enables drop, and no done or error is reported.

## Structure
- Package `coprocessor_pkg` holds:
  - the state enum;
  - config field LSB/MSB constants: MU 23:16, GAMMA 15:8, LAMBDA 7:0;
  - `CONFIG_ADDR`=0.
- Sub-module `host_mem_bridge` holds the registered forwarding stage: write-priority mux plus the FETCH-read override, enabled by the sequencer.

## Test plan
- Config 0x00_02_02_03 (μ=2, γ=2, λ=3) with a processor model raising `in_result_ready` 5 cycles after index_ready → exactly 6 indices in order (0,0)(0,1)(1,0)(1,1)(2,0)(2,1), a ROW_GAP before rows 1 and 2, one `out_done`, `out_error`=0.
- γ=0, λ=4 → `out_index_ready` never asserts; `out_done` pulses 3 cycles after `in_start`.
- Processor issues read @0x09, then write @0x0C data 0xA5.. in consecutive cycles → memory port shows the same commands one cycle later. With both enables asserted, the write wins.
- Processor never raises `in_result_ready`, timeout_cycles=16 → `out_error`=1 sixteen cycles after index_ready, grant drops, done pulses; the next `in_start` clears the error.
- `in_reset` asserted mid-WAIT_RESULT → all outputs 0 asynchronously. A new job then runs cleanly from (0,0).
- `in_start` pulsed during busy → ignored: index sequence and done count unchanged.
